demux_stream_1to4: RTL and testbench

- Registered, handshaked 1-to-4 stream distributor. It sits directly upstream of the four consumers that the combinational 1-to-4 demux would otherwise feed.
- Takes one valid/ready input stream and routes each word to one of four output channels. The route comes either from the addressed select (in_sel) or from an internal round-robin pointer.
- Each channel has a one-entry output holding register, so a stalled consumer blocks only words headed for that channel.
- Per-channel accept counters are provided for debug and coverage.

---
 rtl/demux_stream_1to4.sv | 73 +++++++
 tb/tb_demux_stream_1to4.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/demux_stream_1to4.sv
// Registered valid/ready 1-to-4 distributor: one-clock latency, one-entry holding register per channel.
// Backpressure: in_ready drops only when the targeted channel is full and its consumer is stalled.
module demux_stream_1to4 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               rr_mode,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [WIDTH-1:0]   out_data0,
  output logic [WIDTH-1:0]   out_data1,
  output logic [WIDTH-1:0]   out_data2,
  output logic [WIDTH-1:0]   out_data3,
  output logic [1:0]         rr_ptr,
  output logic [4*CNT_W-1:0] acc_cnt
);

  logic [1:0]       r_ptr;
  logic [3:0]       r_vld;
  logic [WIDTH-1:0] r_dat [4];
  logic [CNT_W-1:0] r_cnt [4];

  logic [1:0] w_tgt;
  logic       w_acc;

  // Round-robin never skips a busy channel, so strict 0,1,2,3 order holds.
  assign w_tgt    = rr_mode ? r_ptr : in_sel;
  assign in_ready = ~r_vld[w_tgt] | out_ready[w_tgt];
  assign w_acc    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 2'd0;
      r_vld <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        r_dat[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        // A fill wins over a same-cycle drain so each channel sustains one word per clock.
        if (w_acc && (w_tgt == 2'(i))) begin
          r_dat[i] <= in_data;
          r_vld[i] <= 1'b1;
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end else if (r_vld[i] && out_ready[i]) begin
          r_vld[i] <= 1'b0;
        end
      end
      if (rr_mode && w_acc) begin
        r_ptr <= r_ptr + 2'd1;
      end
    end
  end

  assign out_valid = r_vld;
  assign out_data0 = r_dat[0];
  assign out_data1 = r_dat[1];
  assign out_data2 = r_dat[2];
  assign out_data3 = r_dat[3];
  assign rr_ptr    = r_ptr;

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    assign acc_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end

endmodule

// File: tb/tb_demux_stream_1to4.sv
// Directed vector bench for demux_stream_1to4 (WIDTH=8, CNT_W=8).
module tb_demux_stream_1to4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        rr_mode;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  out_data0, out_data1, out_data2, out_data3;
  logic [1:0]  rr_ptr;
  logic [31:0] acc_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  demux_stream_1to4 #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .rr_mode(rr_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .rr_ptr(rr_ptr), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] dat;
    logic [1:0] sel;
    logic       rr;
    logic [3:0] ordy;
    logic       e_irdy;   // in_ready before the edge
    logic [3:0] e_ovld;   // after the edge
    logic [1:0] e_ptr;
    logic [31:0] e_cnt;   // {c3,c2,c1,c0}
    int         e_ch;
    logic [7:0] e_dat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ch_data(input int ch);
    case (ch)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  task automatic drive(input logic r, input logic v, input logic [7:0] d,
                       input logic [1:0] s, input logic m, input logic [3:0] o);
    rst = r; in_valid = v; in_data = d; in_sel = s; rr_mode = m; out_ready = o;
  endtask

  initial begin
    // rst vld dat sel rr ordy | irdy ovld ptr cnt ch dat
    // addressed, all consumers ready
    tbl.push_back('{0,1,8'hA0,0,0,4'hF, 1,4'b0001,0,32'h00000001,0,8'hA0});
    tbl.push_back('{0,1,8'hA1,1,0,4'hF, 1,4'b0010,0,32'h00000101,1,8'hA1});
    tbl.push_back('{0,1,8'hA2,2,0,4'hF, 1,4'b0100,0,32'h00010101,2,8'hA2});
    tbl.push_back('{0,1,8'hA3,3,0,4'hF, 1,4'b1000,0,32'h01010101,3,8'hA3});
    // channel 2 stalled; channel 1 still accepts
    tbl.push_back('{0,1,8'h11,2,0,4'b1011, 1,4'b0100,0,32'h01020101,2,8'h11});
    tbl.push_back('{0,1,8'h22,2,0,4'b1011, 0,4'b0100,0,32'h01020101,2,8'h11});
    tbl.push_back('{0,1,8'h33,1,0,4'b1011, 1,4'b0110,0,32'h01020201,1,8'h33});
    tbl.push_back('{0,1,8'h22,2,0,4'b1011, 0,4'b0100,0,32'h01020201,2,8'h11});
    tbl.push_back('{0,1,8'h22,2,0,4'hF,    1,4'b0100,0,32'h01030201,2,8'h22});
    tbl.push_back('{0,0,8'h00,2,0,4'hF,    1,4'b0000,0,32'h01030201,2,8'h22});
    // round-robin, six back-to-back words
    tbl.push_back('{0,1,8'h01,0,1,4'hF, 1,4'b0001,1,32'h01030202,0,8'h01});
    tbl.push_back('{0,1,8'h02,0,1,4'hF, 1,4'b0010,2,32'h01030302,1,8'h02});
    tbl.push_back('{0,1,8'h03,0,1,4'hF, 1,4'b0100,3,32'h01040302,2,8'h03});
    tbl.push_back('{0,1,8'h04,0,1,4'hF, 1,4'b1000,0,32'h02040302,3,8'h04});
    tbl.push_back('{0,1,8'h05,0,1,4'hF, 1,4'b0001,1,32'h02040303,0,8'h05});
    tbl.push_back('{0,1,8'h06,0,1,4'hF, 1,4'b0010,2,32'h02040403,1,8'h06});
    // round-robin stall on channel 1
    tbl.push_back('{0,1,8'h07,0,1,4'b1101, 1,4'b0110,3,32'h02050403,2,8'h07});
    tbl.push_back('{0,1,8'h08,0,1,4'b1101, 1,4'b1010,0,32'h03050403,3,8'h08});
    tbl.push_back('{0,1,8'h09,0,1,4'b1101, 1,4'b0011,1,32'h03050404,0,8'h09});
    tbl.push_back('{0,1,8'h0A,0,1,4'b1101, 0,4'b0010,1,32'h03050404,1,8'h06});
    tbl.push_back('{0,1,8'h0A,0,1,4'b1101, 0,4'b0010,1,32'h03050404,2,8'h07});
    tbl.push_back('{0,1,8'h0A,0,1,4'hF,    1,4'b0010,2,32'h03050504,1,8'h0A});
    tbl.push_back('{0,1,8'h0B,0,1,4'hF,    1,4'b0100,3,32'h03060504,2,8'h0B});
    tbl.push_back('{0,0,8'h00,0,1,4'hF,    1,4'b0000,3,32'h03060504,2,8'h0B});
    // mode toggle keeps the pointer
    tbl.push_back('{0,1,8'h0C,0,0,4'hF, 1,4'b0001,3,32'h03060505,0,8'h0C});
    tbl.push_back('{0,1,8'h0D,0,1,4'hF, 1,4'b1000,0,32'h04060505,3,8'h0D});
    // load channels 0 and 2, then reset with a word offered
    tbl.push_back('{0,1,8'h0E,0,1,4'h0, 1,4'b1001,1,32'h04060506,0,8'h0E});
    tbl.push_back('{0,1,8'h0F,2,0,4'h0, 1,4'b1101,1,32'h04070506,2,8'h0F});
    tbl.push_back('{1,1,8'hEE,1,0,4'h0, 1,4'b0000,0,32'h00000000,1,8'h00});
    tbl.push_back('{0,0,8'h00,1,0,4'hF, 1,4'b0000,0,32'h00000000,1,8'h00});

    drive(1, 0, 8'h00, 0, 0, 4'hF);
    repeat (2) @(posedge clk);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drive(tbl[k].rst, tbl[k].vld, tbl[k].dat, tbl[k].sel, tbl[k].rr, tbl[k].ordy);
      #1;
      chk($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(tbl[k].e_irdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(tbl[k].e_ovld));
      chk($sformatf("v%0d rr_ptr", k), 32'(rr_ptr), 32'(tbl[k].e_ptr));
      chk($sformatf("v%0d acc_cnt", k), acc_cnt, tbl[k].e_cnt);
      chk($sformatf("v%0d out_data%0d", k, tbl[k].e_ch), 32'(ch_data(tbl[k].e_ch)), 32'(tbl[k].e_dat));
    end

    // counter wrap: 256 accepts to channel 3 from a fresh reset
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      drive(0, 1, 8'(n), 3, 0, 4'hF);
      #1;
      chk($sformatf("wrap%0d in_ready", n), 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    chk("wrap acc_cnt", acc_cnt, 32'h00000000);
    chk("wrap out_data3", 32'(out_data3), 32'h000000FF);
    chk("wrap out_valid", 32'(out_valid), 32'h00000008);
    @(negedge clk);
    drive(0, 1, 8'h5A, 3, 0, 4'hF);
    @(posedge clk);
    #1;
    chk("post-wrap acc_cnt", acc_cnt, 32'h01000000);
    chk("post-wrap out_data3", 32'(out_data3), 32'h0000005A);
    @(negedge clk);
    drive(0, 0, 8'h00, 3, 0, 4'hF);
    @(posedge clk);
    #1;
    chk("final out_valid", 32'(out_valid), 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
